// File: rtl/bpu_io_pkg.sv
// Shared definitions for BatPU2 memory-mapped I/O peripherals: UART FSM states,
// status bit positions and default register addresses (0xFF belongs to switches/display).
package bpu_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;

  localparam logic [7:0] DEF_TX_ADDR   = 8'hFD;
  localparam logic [7:0] DEF_STAT_ADDR = 8'hFE;
  localparam logic [7:0] SWITCH_ADDR   = 8'hFF;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and occupancy count.
// DEPTH must be a power of two; a push is accepted only if the FIFO is not full before the edge.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       sync_rst,
  input  logic                       clk_en,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full     = (count_r == (AW+1)'(DEPTH));
  assign empty    = (count_r == (AW+1)'(0));
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  // Qualify requests against the pre-edge occupancy.
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    if (clk_en) begin
      push_ok_s = push && !full;
      pop_ok_s  = pop && !empty;
    end else begin
      push_ok_s = 1'b0;
      pop_ok_s  = 1'b0;
    end
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and registered status read path.
// Define MMIO_UART_PARITY_EN to insert an even parity bit (8E1 framing).
module mmio_uart_tx
  import bpu_io_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] TX_ADDR      = DEF_TX_ADDR,
  parameter logic [7:0] STAT_ADDR    = DEF_STAT_ADDR
) (
  input  logic       clk,
  input  logic       sync_rst,
  input  logic       clk_en,
  input  logic [7:0] data_address,
  input  logic [7:0] data_in,
  input  logic       mem_we,
  input  logic       mem_req,
  output logic [7:0] rd_data,
  output logic       rd_hit,
  output logic       tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state_r;
  logic [7:0]        shift_r;
  logic [2:0]        bit_cnt_r;
  logic [BAUD_W-1:0] baud_r;
  logic              tx_r;
  logic              ovf_r;
  logic [7:0]        rd_data_r;
  logic              rd_hit_r;
`ifdef MMIO_UART_PARITY_EN
  logic              parity_r;
`endif

  logic              push_s;
  logic              pop_s;
  logic              ovf_set_s;
  logic              ovf_clr_s;
  logic [7:0]        pop_data_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic [7:0]        status_s;
  logic              baud_wrap_s;

  assign tx      = tx_r;
  assign rd_data = rd_data_r;
  assign rd_hit  = rd_hit_r;
  assign baud_wrap_s = (baud_r == BAUD_LAST);

  io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .sync_rst  (sync_rst),
    .clk_en    (clk_en),
    .push      (push_s),
    .push_data (data_in),
    .pop       (pop_s),
    .pop_data  (pop_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Bus store decode; the room check uses occupancy before any same-edge pop.
  always_comb begin
    push_s    = 1'b0;
    ovf_set_s = 1'b0;
    ovf_clr_s = 1'b0;
    if (clk_en && mem_we && (data_address == TX_ADDR)) begin
      if (fifo_count_s < CNT_W'(FIFO_DEPTH)) begin
        push_s = 1'b1;
      end else begin
        ovf_set_s = 1'b1;
      end
    end else if (clk_en && mem_we && (data_address == STAT_ADDR)) begin
      ovf_clr_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // FIFO pop request: the FSM takes a byte whenever it idles with data waiting.
  always_comb begin
    pop_s = 1'b0;
    if (clk_en && (state_r == ST_IDLE) && !fifo_empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Status register image.
  always_comb begin
    status_s                 = 8'h00;
    status_s[STAT_FULL_BIT]  = fifo_full_s;
    status_s[STAT_EMPTY_BIT] = fifo_empty_s;
    status_s[STAT_BUSY_BIT]  = (state_r != ST_IDLE);
    status_s[STAT_OVF_BIT]   = ovf_r;
  end

  // Sticky overflow flag.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr_s) begin
      ovf_r <= 1'b0;
    end
  end

  // Registered load path, one enabled cycle of latency like the data RAM.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      rd_data_r <= 8'h00;
      rd_hit_r  <= 1'b0;
    end else if (clk_en && mem_req) begin
      if (data_address == STAT_ADDR) begin
        rd_data_r <= status_s;
        rd_hit_r  <= 1'b1;
      end else if (data_address == TX_ADDR) begin
        rd_data_r <= 8'h00;
        rd_hit_r  <= 1'b1;
      end else begin
        rd_hit_r  <= 1'b0;
      end
    end
  end

  // Serializer FSM; tx is driven from the state one cycle behind it, so it never glitches.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_r   <= ST_IDLE;
      tx_r      <= 1'b1;
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
      baud_r    <= BAUD_W'(0);
`ifdef MMIO_UART_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else if (clk_en) begin
      case (state_r)
        ST_IDLE: begin
          tx_r   <= 1'b1;
          baud_r <= BAUD_W'(0);
          if (!fifo_empty_s) begin
            shift_r   <= pop_data_s;
            bit_cnt_r <= 3'd0;
`ifdef MMIO_UART_PARITY_EN
            parity_r  <= even_parity(pop_data_s);
`endif
            state_r   <= ST_START;
          end
        end
        ST_START: begin
          tx_r <= 1'b0;
          if (baud_wrap_s) begin
            baud_r  <= BAUD_W'(0);
            state_r <= ST_DATA;
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          tx_r <= shift_r[0];
          if (baud_wrap_s) begin
            baud_r    <= BAUD_W'(0);
            shift_r   <= {1'b0, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
              state_r <= ST_PARITY;
`else
              state_r <= ST_STOP;
`endif
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
`ifdef MMIO_UART_PARITY_EN
        ST_PARITY: begin
          tx_r <= parity_r;
          if (baud_wrap_s) begin
            baud_r  <= BAUD_W'(0);
            state_r <= ST_STOP;
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
`endif
        ST_STOP: begin
          tx_r <= 1'b1;
          if (baud_wrap_s) begin
            baud_r  <= BAUD_W'(0);
            state_r <= ST_IDLE;
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        default: begin
          tx_r    <= 1'b1;
          baud_r  <= BAUD_W'(0);
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
